// File: rtl/multiword_add_seq_pkg.sv
// Shared types and default sizing for the multi-word add/subtract sequencer.
package multiword_add_seq_pkg;

    localparam int unsigned DEF_N         = 4;
    localparam int unsigned DEF_MAX_WORDS = 8;

    // FIRST: next accepted beat opens a new operation; BUSY: mid-operation
    typedef enum logic {
        FIRST = 1'b0,
        BUSY  = 1'b1
    } state_e;

endpackage

// File: rtl/multiword_add_seq_core.sv
// Combinational N-bit ripple-carry adder.
//   co  : carry out of the top bit
//   sum : N-bit sum word
//   a,b : N-bit addends
//   ci  : carry in to bit 0
module ripple_add_core #(
    parameter int unsigned N = 4
) (
    output logic         co,
    output logic [N-1:0] sum,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci
);

    // Bit-serial carry chain, LSB to MSB
    always_comb begin
        logic c;
        c   = ci;
        sum = '0;
        for (int i = 0; i < int'(N); i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c      = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequences wide add/subtract through one N-bit adder, one word per beat,
// least-significant word first, with a registered inter-word carry.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : operand beat handshake
//   in_a, in_b            : operand words
//   in_sub                : subtract (sampled on first beat of an operation)
//   in_last               : most-significant word of the operation
//   out_valid/out_ready   : result beat handshake
//   out_sum, out_idx      : result word and its beat index
//   out_last, out_co      : final-word flag, carry (borrow = 0 on subtract)
//   out_ovf, out_trunc    : signed overflow, operation forced to end at MAX_WORDS
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter  int unsigned N         = DEF_N,
    parameter  int unsigned MAX_WORDS = DEF_MAX_WORDS,
    localparam int unsigned CW        = $clog2(MAX_WORDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_a,
    input  logic [N-1:0]  in_b,
    input  logic          in_sub,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_sum,
    output logic [CW-1:0] out_idx,
    output logic          out_last,
    output logic          out_co,
    output logic          out_ovf,
    output logic          out_trunc
);

    state_e        state;
    logic          sub_q;
    logic          carry_q;
    logic [CW-1:0] beat_cnt;

    logic          accept;
    logic          first;
    logic          sub_eff;
    logic          cin;
    logic [N-1:0]  b_eff;
    logic [N-1:0]  sum;
    logic          co;
    logic          end_beat;

    // Output register can be refilled when empty or being drained this cycle
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // First beat takes the mode and carry-in straight from in_sub
    assign first    = (state == FIRST);
    assign sub_eff  = first ? in_sub : sub_q;
    assign cin      = first ? in_sub : carry_q;
    assign b_eff    = in_b ^ {N{sub_eff}};

    // Operation ends on in_last or when the beat counter hits its limit
    assign end_beat = in_last || (beat_cnt == CW'(MAX_WORDS - 1));

    ripple_add_core #(.N(N)) u_add (
        .co  (co),
        .sum (sum),
        .a   (in_a),
        .b   (b_eff),
        .ci  (cin)
    );

    // Control state, carry and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= FIRST;
            sub_q     <= 1'b0;
            carry_q   <= 1'b0;
            beat_cnt  <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            out_co    <= 1'b0;
            out_ovf   <= 1'b0;
            out_trunc <= 1'b0;
        end else if (accept) begin
            carry_q   <= co;
            if (first) begin
                sub_q <= in_sub;
            end
            out_valid <= 1'b1;
            out_sum   <= sum;
            out_idx   <= beat_cnt;
            out_co    <= co;
            out_ovf   <= (in_a[N-1] == b_eff[N-1]) && (sum[N-1] != in_a[N-1]);
            out_last  <= end_beat;
            out_trunc <= end_beat && !in_last;
            if (end_beat) begin
                state    <= FIRST;
                beat_cnt <= '0;
            end else begin
                state    <= BUSY;
                beat_cnt <= beat_cnt + CW'(1);
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
